// File: rtl/mantissa_normalizer.sv
// mantissa_normalizer
//   Normalizes a 25-bit mantissa (carry-out at bit 24, hidden bit at bit 23)
//   and adjusts its biased exponent. A carry-out is absorbed with a single
//   right shift. Otherwise the mantissa is shifted left one bit per cycle
//   until the hidden bit is set or the exponent reaches zero.
//
// Ports
//   CLK      in   1   rising-edge clock
//   RSTN     in   1   synchronous active-low reset
//   START    in   1   request to normalize IN/EXP_IN, sampled only in IDLE
//   IN       in  25   unnormalized mantissa
//   EXP_IN   in   8   biased exponent paired with IN
//   OUT      out 24   normalized mantissa, hidden bit at 23
//   EXP_OUT  out  8   adjusted biased exponent
//   BY       out  8   shift applied, two's complement (+left / -right)
//   BUSY     out  1   high while normalizing
//   DONE     out  1   one-cycle result-valid strobe
//   ZERO     out  1   mantissa was zero
//   OVF      out  1   exponent reached 8'hFF after a right shift
//   UNF      out  1   left shifting stopped at exponent 0
module mantissa_normalizer (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        START,
    input  logic [24:0] IN,
    input  logic [7:0]  EXP_IN,
    output logic [23:0] OUT,
    output logic [7:0]  EXP_OUT,
    output logic [7:0]  BY,
    output logic        BUSY,
    output logic        DONE,
    output logic        ZERO,
    output logic        OVF,
    output logic        UNF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    logic [24:0] m;
    logic [7:0]  e;
    logic [7:0]  e_inc;

    assign e_inc   = e + 8'd1;
    assign OUT     = m[23:0];
    assign EXP_OUT = e;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= IDLE;
            m     <= '0;
            e     <= '0;
            BY    <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ZERO  <= 1'b0;
            OVF   <= 1'b0;
            UNF   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        m     <= IN;
                        e     <= EXP_IN;
                        BY    <= '0;
                        ZERO  <= 1'b0;
                        OVF   <= 1'b0;
                        UNF   <= 1'b0;
                        BUSY  <= 1'b1;
                        state <= NORM;
                    end
                end

                NORM: begin
                    // Rules are prioritized; every rule except the left
                    // shift ends the operation and raises DONE next cycle.
                    if (m == '0) begin
                        ZERO  <= 1'b1;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else if (m[24]) begin
                        m     <= m >> 1;
                        e     <= e_inc;
                        BY    <= 8'hFF;
                        OVF   <= (e_inc == 8'hFF);
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else if (m[23]) begin
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else if (e == '0) begin
                        UNF   <= 1'b1;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        // m[24] and m[23] are both 0 here, so bit 24 stays 0.
                        m     <= {m[23:0], 1'b0};
                        e     <= e - 8'd1;
                        BY    <= BY + 8'd1;
                    end
                end

                FIN: begin
                    DONE  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
